fetch_unit: RTL

Program-counter and fetch stage sitting directly upstream of the instruction ROM. Drives the ROM address each cycle, registers the returned instruction into an instruction register (IR) for the decode stage, and handles the control flow around fetch: start, stall, absolute branch with one-cycle squash, halt detection and cycle counting. Together with the ROM it forms the front end of the processor.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/sat_counter.sv | 10 +
 rtl/fetch_unit.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and halt encoding for the fetch stage
package fetch_pkg;
  localparam int A = 10;
  localparam int W = 9;
  localparam int CW = 16;
  localparam logic [W-1:0] HALT_INST = '1;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: N-bit up counter with enable and sync clear, sticks at all-ones (clk, clr, en -> q)
module sat_counter #(parameter int N = 16) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    q <= clr ? '0 : (en && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with start, stall, branch squash, halt and run-cycle count (Clk, Reset, Start, Stall, BranchEn, Target, InstIn -> InstAddress, InstReg, InstValid, Done, CycleCount)
module fetch_unit
  import fetch_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [A-1:0]  Target,
  input  logic [W-1:0]  InstIn,
  output logic [A-1:0]  InstAddress,
  output logic [W-1:0]  InstReg,
  output logic          InstValid,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);
  state_t state, state_n;
  logic [A-1:0] pc_n;
  logic [W-1:0] ir_n;
  logic valid_n, done_n, halt;
  assign halt = InstValid && InstReg == HALT_INST;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      InstAddress <= '0;
      InstReg <= '0;
      InstValid <= 1'b0;
      Done <= 1'b0;
    end else begin
      state <= state_n;
      InstAddress <= pc_n;
      InstReg <= ir_n;
      InstValid <= valid_n;
      Done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = InstAddress;
    ir_n = InstReg;
    valid_n = InstValid;
    done_n = Done;
    if (state == IDLE && Start) begin
      state_n = RUN;
    end else if (state == HALTED && Start) begin
      state_n = RUN;
      pc_n = '0;
      done_n = 1'b0;
    end else if (state == RUN && !Stall) begin
      if (halt) begin
        state_n = HALTED;
        done_n = 1'b1;
        valid_n = 1'b0;
      end else if (BranchEn) begin
        pc_n = Target;
        valid_n = 1'b0;
      end else begin
        ir_n = InstIn;
        valid_n = 1'b1;
        pc_n = InstAddress + 1'b1;
      end
    end
  end
  sat_counter #(.N(CW)) u_cycles (
    .clk(Clk),
    .clr(!Reset || (state == HALTED && Start)),
    .en(state == RUN),
    .q(CycleCount)
  );
endmodule
